// File: rtl/mega_ram_pkg.sv
// mega_ram_pkg
//   Shared types and constants for the mega core data-RAM arbiter.
//   owner_t : which master a read issued last cycle belongs to.
//   gnt_t   : which master (if any) is issued to the RAM this cycle.
package mega_ram_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_t;

    // First address that may not be written (boot/ROM shadow region above it).
    localparam int WR_LIMIT_DEF = 'hB00;

    // Starvation counter width; MAX_WAIT is limited to 1..255.
    localparam int STARVE_CNT_W = 8;

endpackage

// File: rtl/mega_ram_arb_starve.sv
// mega_ram_arb_starve
//   Saturating count of consecutive cycles a pending DMA request lost to the
//   CPU. When the count reaches MAX_WAIT the DMA is forced onto the RAM.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_halt       : RAM halted, count holds
//   i_dma_req    : DMA request pending
//   i_dma_gnt    : DMA issued this cycle (clears the count)
//   i_cpu_gnt    : CPU issued this cycle (counts if DMA was waiting)
//   o_force      : count has reached MAX_WAIT
module mega_ram_arb_starve
    import mega_ram_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_halt,
    input  logic i_dma_req,
    input  logic i_dma_gnt,
    input  logic i_cpu_gnt,
    output logic o_force
);

    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(MAX_WAIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_halt) begin
            r_cnt <= r_cnt;
        end else if (i_dma_gnt) begin
            r_cnt <= '0;
        end else if (i_cpu_gnt && i_dma_req) begin
            // Saturate so a DMA refused while forced (cannot happen with a
            // well-behaved DMA) never wraps back to zero.
            if (r_cnt != LIM) begin
                r_cnt <= r_cnt + STARVE_CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_force = (r_cnt == LIM);

endmodule

// File: rtl/mega_ram_arb.sv
// mega_ram_arb
//   Two-master arbiter in front of the mega core data RAM. The CPU data bus
//   has priority; a starvation counter guarantees the DMA master a slot. The
//   RAM has a one-cycle registered read, so the owner of each read is kept for
//   one cycle and the returned data is steered to that master.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   cpu_cs/we/re/a/d_in         : CPU request (held while cpu_stall)
//   cpu_d_out                   : CPU read data, cycle after the granted read
//   cpu_stall                   : CPU request not taken this cycle
//   dma_req/we/a/d_in           : DMA request (held until dma_ack)
//   dma_ack                     : DMA request issued this cycle
//   dma_rd_valid, dma_d_out     : DMA read return, cycle after a read ack
//   wr_err                      : pulse, a write at/above WR_LIMIT was dropped
//   ram_cs/we/re/a/d_in         : RAM command
//   ram_d_out                   : RAM read data (valid while ram_cs&ram_re)
//   ram_halt                    : RAM clearing, nothing is issued
module mega_ram_arb
    import mega_ram_pkg::*;
#(
    parameter int                        ADDR_BUS_WIDTH = 12,
    parameter int                        DATA_BUS_WIDTH = 8,
    parameter int                        MAX_WAIT       = 8,
    parameter logic [ADDR_BUS_WIDTH-1:0] WR_LIMIT       = ADDR_BUS_WIDTH'(WR_LIMIT_DEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_cs,
    input  logic                      cpu_we,
    input  logic                      cpu_re,
    input  logic [ADDR_BUS_WIDTH-1:0] cpu_a,
    input  logic [DATA_BUS_WIDTH-1:0] cpu_d_in,
    output logic [DATA_BUS_WIDTH-1:0] cpu_d_out,
    output logic                      cpu_stall,
    input  logic                      dma_req,
    input  logic                      dma_we,
    input  logic [ADDR_BUS_WIDTH-1:0] dma_a,
    input  logic [DATA_BUS_WIDTH-1:0] dma_d_in,
    output logic                      dma_ack,
    output logic                      dma_rd_valid,
    output logic [DATA_BUS_WIDTH-1:0] dma_d_out,
    output logic                      wr_err,
    output logic                      ram_cs,
    output logic                      ram_we,
    output logic                      ram_re,
    output logic [ADDR_BUS_WIDTH-1:0] ram_a,
    output logic [DATA_BUS_WIDTH-1:0] ram_d_in,
    input  logic [DATA_BUS_WIDTH-1:0] ram_d_out,
    input  logic                      ram_halt
);

    owner_t                    r_owner;
    owner_t                    w_owner_nxt;
    logic                      r_wr_err;
    gnt_t                      w_gnt;
    logic                      w_force;
    logic                      w_op_we;
    logic                      w_op_re;
    logic [ADDR_BUS_WIDTH-1:0] w_op_a;
    logic [DATA_BUS_WIDTH-1:0] w_op_d;
    logic                      w_wr_block;
    logic                      w_ret;

    mega_ram_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_halt    (ram_halt),
        .i_dma_req (dma_req),
        .i_dma_gnt (w_gnt == GNT_DMA),
        .i_cpu_gnt (w_gnt == GNT_CPU),
        .o_force   (w_force)
    );

    // Issue decision. Reset is folded in so nothing reaches the RAM while
    // rst is high, even though the RAM port is purely combinational.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!rst && !ram_halt) begin
            if (dma_req && (w_force || !cpu_cs)) begin
                w_gnt = GNT_DMA;
            end else if (cpu_cs) begin
                w_gnt = GNT_CPU;
            end
        end
    end

    // Selected operation and the owner of any read it starts.
    always_comb begin
        w_op_we     = 1'b0;
        w_op_re     = 1'b0;
        w_op_a      = '0;
        w_op_d      = '0;
        w_owner_nxt = OWN_NONE;
        case (w_gnt)
            GNT_CPU: begin
                w_op_we = cpu_we;
                w_op_re = cpu_re;
                w_op_a  = cpu_a;
                w_op_d  = cpu_d_in;
                if (cpu_re) begin
                    w_owner_nxt = OWN_CPU;
                end
            end
            GNT_DMA: begin
                w_op_we = dma_we;
                w_op_re = !dma_we;
                w_op_a  = dma_a;
                w_op_d  = dma_d_in;
                if (!dma_we) begin
                    w_owner_nxt = OWN_DMA;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= OWN_NONE;
            r_wr_err <= 1'b0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_wr_err <= w_wr_block;
        end
    end

    // A write into the protected region is still granted/acked, only the
    // RAM write strobe is suppressed.
    assign w_wr_block = w_op_we && (w_op_a >= WR_LIMIT);

    // Return cycle: the RAM output is gated by cs&re, so both are held high
    // while the previous cycle's read data is on ram_d_out.
    assign w_ret = !rst && (r_owner != OWN_NONE);

    assign ram_cs   = (w_gnt != GNT_NONE) || w_ret;
    assign ram_re   = w_op_re || w_ret;
    assign ram_we   = w_op_we && !w_wr_block;
    assign ram_a    = w_op_a;
    assign ram_d_in = w_op_d;

    assign cpu_stall    = cpu_cs && (w_gnt != GNT_CPU);
    assign dma_ack      = (w_gnt == GNT_DMA);
    assign wr_err       = r_wr_err;

    assign cpu_d_out    = (w_ret && r_owner == OWN_CPU) ? ram_d_out : '0;
    assign dma_rd_valid = w_ret && (r_owner == OWN_DMA);
    assign dma_d_out    = (w_ret && r_owner == OWN_DMA) ? ram_d_out : '0;

endmodule

// File: tb/tb_mega_ram_arb.sv
module tb_mega_ram_arb;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int MW = 8;
    localparam int LIMIT = 'hB00;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_cs, cpu_we, cpu_re;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_d_in, cpu_d_out;
    logic          cpu_stall;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_a;
    logic [DW-1:0] dma_d_in, dma_d_out;
    logic          dma_ack, dma_rd_valid, wr_err;
    logic          ram_cs, ram_we, ram_re;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d_in, ram_d_out;
    logic          ram_halt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mega_ram_arb #(
        .ADDR_BUS_WIDTH (AW),
        .DATA_BUS_WIDTH (DW),
        .MAX_WAIT       (MW),
        .WR_LIMIT       (12'hB00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_cs       (cpu_cs),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_a        (cpu_a),
        .cpu_d_in     (cpu_d_in),
        .cpu_d_out    (cpu_d_out),
        .cpu_stall    (cpu_stall),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_a        (dma_a),
        .dma_d_in     (dma_d_in),
        .dma_ack      (dma_ack),
        .dma_rd_valid (dma_rd_valid),
        .dma_d_out    (dma_d_out),
        .wr_err       (wr_err),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_re       (ram_re),
        .ram_a        (ram_a),
        .ram_d_in     (ram_d_in),
        .ram_d_out    (ram_d_out),
        .ram_halt     (ram_halt)
    );

    // Behavioural RAM: registered read, output gated by cs&re.
    logic [DW-1:0] mem [0:4095] = '{default: 8'h00};
    logic [DW-1:0] ram_q = 8'h00;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_a] <= ram_d_in;
        if (ram_cs && ram_re) ram_q <= mem[ram_a];
    end
    assign ram_d_out = (ram_cs && ram_re) ? ram_q : 8'h00;

    typedef struct {
        string         name;
        logic          halt, cs, we, re;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dreq, dwe;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          e_stall, e_ack, e_cs, e_we, e_re;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cpu_cs = 0; cpu_we = 0; cpu_re = 0; cpu_a = '0; cpu_d_in = '0;
        dma_req = 0; dma_we = 0; dma_a = '0; dma_d_in = '0;
        ram_halt = 0;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_cs = 1; cpu_we = we; cpu_re = !we; cpu_a = a; cpu_d_in = d;
    endtask

    task automatic dma_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req = 1; dma_we = we; dma_a = a; dma_d_in = d;
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 9) == 0) return 12'hB00 + AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, 15));
    endfunction

    // Reference model state for the random phase.
    logic [DW-1:0] shadow [0:4095];
    int            m_cnt, m_own, g;
    logic [DW-1:0] m_rdat;
    logic          m_werr;

    initial begin
        int halt_stall_bad, halt_cs_bad;
        logic          op_we, op_re;
        logic [AW-1:0] op_a;
        logic [DW-1:0] op_d;
        logic          e_stall, e_ack, e_cs, e_we, e_re, e_dv;
        logic [DW-1:0] e_cd, e_dd;
        logic          c_hold, d_hold;

        vecs[0]  = '{"halt_cpu",   1,1,0,1,12'h010,8'h00, 0,0,12'h000,8'h00, 1,0,0,0,0};
        vecs[1]  = '{"halt_dma",   1,0,0,0,12'h000,8'h00, 1,0,12'h020,8'h00, 0,0,0,0,0};
        vecs[2]  = '{"cpu_rd",     0,1,0,1,12'h010,8'h00, 0,0,12'h000,8'h00, 0,0,1,0,1};
        vecs[3]  = '{"cpu_wr",     0,1,1,0,12'h200,8'hA5, 0,0,12'h000,8'h00, 0,0,1,1,0};
        vecs[4]  = '{"cpu_wr_lim", 0,1,1,0,12'hB00,8'hA5, 0,0,12'h000,8'h00, 0,0,1,0,0};
        vecs[5]  = '{"dma_rd",     0,0,0,0,12'h000,8'h00, 1,0,12'h020,8'h00, 0,1,1,0,1};
        vecs[6]  = '{"dma_wr",     0,0,0,0,12'h000,8'h00, 1,1,12'h300,8'h3C, 0,1,1,1,0};
        vecs[7]  = '{"dma_wr_top", 0,0,0,0,12'h000,8'h00, 1,1,12'hBFF,8'h3C, 0,1,1,0,0};
        vecs[8]  = '{"cpu_wins",   0,1,0,1,12'h011,8'h00, 1,0,12'h021,8'h00, 0,0,1,0,1};
        vecs[9]  = '{"idle",       0,0,0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,0,0};
        vecs[10] = '{"cpu_wr_aff", 0,1,1,0,12'hAFF,8'h5A, 0,0,12'h000,8'h00, 0,0,1,1,0};

        idle_in();
        rst = 1;
        step(); step();

        // Reset state
        rst = 0;
        #4;
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_cpu_d_out", cpu_d_out, 0);
        chk("rst_dma_rd_valid", dma_rd_valid, 0);
        step();

        // RAM halt for 256 cycles with the CPU requesting
        halt_stall_bad = 0;
        halt_cs_bad = 0;
        ram_halt = 1;
        cpu_op(0, 12'h010, 8'h00);
        for (int i = 0; i < 256; i++) begin
            #4;
            if (cpu_stall !== 1'b1) halt_stall_bad++;
            if (ram_cs !== 1'b0) halt_cs_bad++;
            step();
        end
        chk("halt_stall_cycles_wrong", halt_stall_bad, 0);
        chk("halt_ram_cs_cycles_wrong", halt_cs_bad, 0);
        ram_halt = 0;
        #4;
        chk("halt_fall_stall", cpu_stall, 0);
        chk("halt_fall_ram_cs", ram_cs, 1);
        step();

        // Single-cycle table
        for (int v = 0; v < 11; v++) begin
            idle_in();
            step();
            ram_halt = vecs[v].halt;
            cpu_cs = vecs[v].cs; cpu_we = vecs[v].we; cpu_re = vecs[v].re;
            cpu_a = vecs[v].ca; cpu_d_in = vecs[v].cd;
            dma_req = vecs[v].dreq; dma_we = vecs[v].dwe;
            dma_a = vecs[v].da; dma_d_in = vecs[v].dd;
            #4;
            chk({vecs[v].name, "_stall"}, cpu_stall, vecs[v].e_stall);
            chk({vecs[v].name, "_ack"}, dma_ack, vecs[v].e_ack);
            chk({vecs[v].name, "_ram_cs"}, ram_cs, vecs[v].e_cs);
            chk({vecs[v].name, "_ram_we"}, ram_we, vecs[v].e_we);
            chk({vecs[v].name, "_ram_re"}, ram_re, vecs[v].e_re);
            step();
        end
        idle_in();
        step();

        // CPU write then read back
        cpu_op(1, 12'h100, 8'h5A);
        #4;
        chk("cw_ram_we", ram_we, 1);
        chk("cw_stall", cpu_stall, 0);
        step();
        cpu_op(0, 12'h100, 8'h00);
        #4;
        chk("cr_stall", cpu_stall, 0);
        chk("cr_ram_we", ram_we, 0);
        step();
        idle_in();
        #4;
        chk("cr_data", cpu_d_out, 8'h5A);
        chk("cr_dma_valid", dma_rd_valid, 0);
        step();

        // Starvation: two rounds, each must ack on the 9th cycle
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= MW + 1; k++) begin
                cpu_op(0, 12'h005, 8'h00);
                dma_op(0, 12'h020, 8'h00);
                #4;
                chk($sformatf("starve_r%0d_c%0d_ack", r, k), dma_ack, (k == MW + 1));
                chk($sformatf("starve_r%0d_c%0d_stall", r, k), cpu_stall, (k == MW + 1));
                step();
            end
        end
        idle_in();
        step();

        // Preload, then interleaved CPU / DMA reads
        cpu_op(1, 12'h010, 8'h11);
        step();
        cpu_op(1, 12'h020, 8'h22);
        step();
        idle_in();
        step();
        cpu_op(0, 12'h010, 8'h00);
        #4;
        chk("il_cpu_granted", cpu_stall, 0);
        step();
        idle_in();
        dma_op(0, 12'h020, 8'h00);
        #4;
        chk("il_dma_ack", dma_ack, 1);
        chk("il_cpu_data", cpu_d_out, 8'h11);
        chk("il_dma_valid_early", dma_rd_valid, 0);
        step();
        idle_in();
        #4;
        chk("il_dma_valid", dma_rd_valid, 1);
        chk("il_dma_data", dma_d_out, 8'h22);
        chk("il_cpu_data_zero", cpu_d_out, 0);
        step();

        // DMA write into the protected region
        dma_op(1, 12'hB00, 8'h77);
        #4;
        chk("wl_ack", dma_ack, 1);
        chk("wl_ram_we", ram_we, 0);
        chk("wl_err_not_yet", wr_err, 0);
        step();
        idle_in();
        #4;
        chk("wl_err", wr_err, 1);
        chk("wl_mem", mem[12'hB00], 8'h00);
        step();
        #4;
        chk("wl_err_pulse", wr_err, 0);
        step();

        // Reset in the return cycle of a DMA read
        dma_op(0, 12'h020, 8'h00);
        #4;
        chk("rr_ack", dma_ack, 1);
        step();
        idle_in();
        rst = 1;
        #4;
        chk("rr_valid", dma_rd_valid, 0);
        chk("rr_data", dma_d_out, 0);
        step();
        rst = 0;
        #4;
        chk("rr_post_valid", dma_rd_valid, 0);
        chk("rr_post_ram_cs", ram_cs, 0);
        chk("rr_post_cpu_d", cpu_d_out, 0);
        chk("rr_post_ack", dma_ack, 0);
        chk("rr_post_wr_err", wr_err, 0);
        step();

        // Randomized run against the reference model
        for (int i = 0; i < 4096; i++) shadow[i] = mem[i];
        m_cnt = 0; m_own = 0; m_werr = 0; m_rdat = 8'h00;
        c_hold = 0; d_hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!c_hold) begin
                if ($urandom_range(0, 99) < 60) cpu_op(1'($urandom_range(0, 1)), raddr(), 8'($urandom));
                else begin cpu_cs = 0; cpu_we = 0; cpu_re = 0; end
            end
            if (!d_hold) begin
                if ($urandom_range(0, 99) < 40) dma_op(1'($urandom_range(0, 1)), raddr(), 8'($urandom));
                else dma_req = 0;
            end
            ram_halt = ($urandom_range(0, 19) == 0);

            if (ram_halt) g = 0;
            else if (dma_req && (m_cnt == MW || !cpu_cs)) g = 2;
            else if (cpu_cs) g = 1;
            else g = 0;

            op_we = 0; op_re = 0; op_a = '0; op_d = '0;
            if (g == 1) begin op_we = cpu_we; op_re = cpu_re; op_a = cpu_a; op_d = cpu_d_in; end
            if (g == 2) begin op_we = dma_we; op_re = !dma_we; op_a = dma_a; op_d = dma_d_in; end

            e_stall = cpu_cs && (g != 1);
            e_ack   = (g == 2);
            e_cs    = (g != 0) || (m_own != 0);
            e_re    = op_re || (m_own != 0);
            e_we    = op_we && (int'(op_a) < LIMIT);
            e_cd    = (m_own == 1) ? m_rdat : 8'h00;
            e_dv    = (m_own == 2);
            e_dd    = (m_own == 2) ? m_rdat : 8'h00;

            #4;
            chk("rnd_stall", cpu_stall, e_stall);
            chk("rnd_ack", dma_ack, e_ack);
            chk("rnd_ram_cs", ram_cs, e_cs);
            chk("rnd_ram_re", ram_re, e_re);
            chk("rnd_ram_we", ram_we, e_we);
            chk("rnd_cpu_d", cpu_d_out, e_cd);
            chk("rnd_dma_v", dma_rd_valid, e_dv);
            chk("rnd_dma_d", dma_d_out, e_dd);
            chk("rnd_wr_err", wr_err, m_werr);
            if (g != 0) chk("rnd_ram_a", ram_a, op_a);

            m_werr = op_we && (int'(op_a) >= LIMIT);
            m_own  = (op_re && g == 1) ? 1 : (op_re && g == 2) ? 2 : 0;
            m_rdat = shadow[op_a];
            if (e_we) shadow[op_a] = op_d;
            if (!ram_halt) begin
                if (g == 2) m_cnt = 0;
                else if (g == 1 && dma_req) m_cnt = (m_cnt < MW) ? m_cnt + 1 : MW;
                else m_cnt = 0;
            end
            c_hold = e_stall;
            d_hold = dma_req && !e_ack;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mega_ram_arb.md
Name: mega_ram_arb

Overview:
- Two-master arbiter directly upstream of the data RAM in the mega core.
- Shares the single RAM port between the CPU data bus and a secondary DMA master (frame-buffer reader / loader).
- CPU has priority. A starvation counter guarantees the DMA a slot.
- Tracks the RAM's one-cycle registered read latency and routes returned data to the correct master.

Parameters:
- ADDR_BUS_WIDTH, 12, RAM address width.
- DATA_BUS_WIDTH, 8, data width.
- MAX_WAIT, 8, max consecutive cycles a pending DMA request may be refused before it is forced (1..255).
- WR_LIMIT, 12'hB00, first non-writable address; writes at or above it are dropped and flagged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_cs  in  1  CPU access select.
- cpu_we  in  1  CPU write.
- cpu_re  in  1  CPU read.
- cpu_a  in  ADDR_BUS_WIDTH  CPU address.
- cpu_d_in  in  DATA_BUS_WIDTH  CPU write data.
- cpu_d_out  out  DATA_BUS_WIDTH  CPU read data, valid the cycle after the granted read.
- cpu_stall  out  1  CPU request not taken this cycle; CPU must hold cs/we/re/a/d_in.
- dma_req  in  1  DMA request, held until dma_ack.
- dma_we  in  1  DMA write (0 = read).
- dma_a  in  ADDR_BUS_WIDTH  DMA address.
- dma_d_in  in  DATA_BUS_WIDTH  DMA write data.
- dma_ack  out  1  request issued to RAM this cycle.
- dma_rd_valid  out  1  dma_d_out valid (cycle after a read ack).
- dma_d_out  out  DATA_BUS_WIDTH  DMA read data.
- wr_err  out  1  one-cycle pulse: a write at or above WR_LIMIT was dropped.
- ram_cs  out  1  RAM select.
- ram_we  out  1  RAM write.
- ram_re  out  1  RAM read.
- ram_a  out  ADDR_BUS_WIDTH  RAM address.
- ram_d_in  out  DATA_BUS_WIDTH  RAM write data.
- ram_d_out  in  DATA_BUS_WIDTH  RAM read data (registered, gated by ram_cs&ram_re).
- ram_halt  in  1  RAM clearing after reset; no access is granted while high.

Behaviour:
- Reset values: all outputs 0, starvation counter 0, return-owner register NONE. The one exception is cpu_stall, which follows the stall rules combinationally.
- Issue decision is combinational each cycle.
  - If ram_halt=1: issue nothing; cpu_stall=cpu_cs; dma_ack=0; counter holds.
  - Else if dma_req and (counter==MAX_WAIT or !cpu_cs): issue the DMA op; dma_ack=1; cpu_stall=cpu_cs; counter cleared.
  - Else if cpu_cs: issue the CPU op; cpu_stall=0. Counter increments (saturating at MAX_WAIT) if dma_req, else clears.
  - Else: idle.
- Issued op drives ram_a, ram_d_in, ram_we and ram_cs=1. ram_re equals the issuing master's re; a DMA read has re=1.
- Write guard: an issued write with address >= WR_LIMIT forces ram_we=0 and registers wr_err=1 for the next cycle. The op still counts as granted/acked.
- Read return:
  - A registered owner (NONE/CPU/DMA) records a read issued in cycle N.
  - In cycle N+1 ram_cs and ram_re are forced to 1, whatever is issued that cycle, so RAM data is visible.
  - If owner=CPU, cpu_d_out=ram_d_out. If owner=DMA, dma_rd_valid=1 and dma_d_out=ram_d_out.
  - The non-owner's data output is 0.
- Back-to-back reads (either master, interleaved) sustain 1 op/cycle. A write issued in a return cycle is legal; ram_re forced high is harmless.
- rst mid-operation: the pending return is discarded (owner=NONE, no dma_rd_valid).
- Simultaneous cpu_cs and dma_req with counter<MAX_WAIT: CPU wins.

Decomposition:
- Shared package mega_ram_pkg: owner encoding (OWN_NONE, OWN_CPU, OWN_DMA) and the WR_LIMIT default constant.
- One natural sub-module: mega_ram_arb_starve, the saturating starvation counter with force output.

Test Plan:
- rst=1 then ram_halt high 256 cycles with cpu_cs=1 -> cpu_stall=1 and ram_cs=0 throughout; first grant on the cycle ram_halt falls.
- CPU write 0x100=0x5A, then CPU read 0x100 -> ram_we pulse, cpu_stall=0; cpu_d_out=0x5A the cycle after the read; dma_rd_valid=0.
- CPU reads every cycle, dma_req held (MAX_WAIT=8) -> dma_ack exactly on the 9th cycle with cpu_stall=1 that cycle; counter back to 0.
- Interleaved CPU read 0x010 (=0x11) then DMA read 0x020 (=0x22) in consecutive cycles -> cpu_d_out=0x11 at N+1; dma_rd_valid=1 with 0x22 at N+2.
- DMA write to 0xB00 -> dma_ack=1, ram_we=0, wr_err=1 next cycle; RAM contents unchanged.
- rst asserted in the return cycle of a DMA read -> dma_rd_valid=0; all outputs at reset values next cycle.
